// File: rtl/gtx_oob_dev.sv
// Device-side SATA OOB responder: answers COMRESET/COMWAKE, locks on host ALIGN,
// sends SYNC, then streams link-layer dwords with periodic ALIGN-pair insertion.
module gtx_oob_dev #(
  parameter int C_COMWAKE_TIMEOUT = 75000,
  parameter int C_ALIGN_TIMEOUT   = 66000,
  parameter int C_ALIGN_PERIOD    = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [2:0]  rxstatus,
  input  logic        rxelecidle,
  input  logic        rxbyteisaligned,
  input  logic [31:0] rxdata,
  input  logic [3:0]  rxdatak,
  input  logic [31:0] txdata_ll,
  input  logic        txdatak_ll,
  output logic        txcomstart,
  output logic        txcomtype,
  output logic        txelecidle,
  output logic [31:0] txdata,
  output logic [3:0]  txdatak,
  output logic        txdatak_pop,
  output logic        link_up,
  output logic [3:0]  oob_state
);

  localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_DW  = 32'hB5B5957C;
  localparam logic [3:0]  K0       = 4'b0001;
  localparam int          WCW      = $clog2(C_ALIGN_PERIOD);
  localparam logic [16:0] COMWAKE_LAST = 17'(C_COMWAKE_TIMEOUT - 1);
  localparam logic [16:0] ALIGN_LAST   = 17'(C_ALIGN_TIMEOUT - 1);
  localparam logic [WCW-1:0] WORD_LAST  = WCW'(C_ALIGN_PERIOD - 1);
  localparam logic [WCW-1:0] WORD_ALIGN = WCW'(C_ALIGN_PERIOD - 2);

  typedef enum logic [3:0] {
    S_IDLE              = 4'd0,
    S_SEND_COMINIT      = 4'd1,
    S_WAIT_COMINIT_DONE = 4'd2,
    S_WAIT_COMWAKE      = 4'd3,
    S_SEND_COMWAKE      = 4'd4,
    S_WAIT_COMWAKE_DONE = 4'd5,
    S_SEND_ALIGN        = 4'd6,
    S_SEND_SYNC         = 4'd7,
    S_LINK_UP           = 4'd8
  } state_t;

  state_t         state_reg, state_next;
  logic [16:0]    timer_reg, timer_next;
  logic [1:0]     sync_cnt_reg, sync_cnt_next;
  logic [WCW-1:0] word_cnt_reg, word_cnt_next;

  logic        txcomstart_next, txcomtype_next, txelecidle_next;
  logic [31:0] txdata_next;
  logic [3:0]  txdatak_next;
  logic        txdatak_pop_next, link_up_next;

  logic comreset, burst_done, comwake, host_align, sync_like;

  assign comreset   = (rxstatus == 3'b011);
  assign burst_done = (rxstatus == 3'b001);
  assign comwake    = (rxstatus == 3'b010);
  assign host_align = rxbyteisaligned && !rxelecidle && (rxdata == ALIGN_DW) && (rxdatak == K0);
  assign sync_like  = rxdatak[0] && (rxdata != ALIGN_DW);
  assign oob_state  = state_reg;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      sync_cnt_reg <= '0;
      word_cnt_reg <= '0;
      txcomstart   <= 1'b0;
      txcomtype    <= 1'b0;
      txelecidle   <= 1'b1;
      txdata       <= '0;
      txdatak      <= '0;
      txdatak_pop  <= 1'b0;
      link_up      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      sync_cnt_reg <= sync_cnt_next;
      word_cnt_reg <= word_cnt_next;
      txcomstart   <= txcomstart_next;
      txcomtype    <= txcomtype_next;
      txelecidle   <= txelecidle_next;
      txdata       <= txdata_next;
      txdatak      <= txdatak_next;
      txdatak_pop  <= txdatak_pop_next;
      link_up      <= link_up_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    sync_cnt_next    = '0;
    txcomstart_next  = 1'b0;
    txcomtype_next   = txcomtype;
    txelecidle_next  = 1'b1;
    txdata_next      = '0;
    txdatak_next     = '0;
    txdatak_pop_next = 1'b0;
    link_up_next     = 1'b0;

    case (state_reg)
      S_IDLE:              if (comreset) state_next = S_SEND_COMINIT;
      S_SEND_COMINIT:      state_next = S_WAIT_COMINIT_DONE;
      S_WAIT_COMINIT_DONE: if (burst_done) state_next = S_WAIT_COMWAKE;
      S_WAIT_COMWAKE: begin
        if (comwake) state_next = S_SEND_COMWAKE;
        else if (timer_reg >= COMWAKE_LAST) state_next = S_SEND_COMINIT;
      end
      S_SEND_COMWAKE:      state_next = S_WAIT_COMWAKE_DONE;
      S_WAIT_COMWAKE_DONE: if (burst_done) state_next = S_SEND_ALIGN;
      S_SEND_ALIGN: begin
        if (host_align) state_next = S_SEND_SYNC;
        else if (timer_reg >= ALIGN_LAST) state_next = S_IDLE;
      end
      S_SEND_SYNC: begin
        if (sync_like) begin
          if (sync_cnt_reg == 2'd2) state_next = S_LINK_UP;
          else sync_cnt_next = sync_cnt_reg + 2'd1;
        end
      end
      S_LINK_UP:           state_next = S_LINK_UP;
      default:             state_next = S_IDLE;
    endcase

    // COMRESET from the host overrides every other transition, timeouts included
    if (comreset && state_reg != S_IDLE && state_reg != S_SEND_COMINIT)
      state_next = S_SEND_COMINIT;

    if (state_next != S_SEND_SYNC) sync_cnt_next = '0;

    // Any state change restarts the timer; it saturates instead of wrapping
    if (state_next != state_reg) timer_next = '0;
    else if (timer_reg == 17'h1FFFF) timer_next = timer_reg;
    else timer_next = timer_reg + 17'd1;

    // word_cnt_reg is zero outside LINK_UP, so the entry edge emits dword 0
    if (state_next == S_LINK_UP)
      word_cnt_next = (word_cnt_reg == WORD_LAST) ? '0 : word_cnt_reg + WCW'(1);
    else
      word_cnt_next = '0;

    case (state_next)
      S_SEND_COMINIT: begin
        txcomstart_next = 1'b1;
        txcomtype_next  = 1'b0;
      end
      S_SEND_COMWAKE: begin
        txcomstart_next = 1'b1;
        txcomtype_next  = 1'b1;
      end
      S_SEND_ALIGN: begin
        txelecidle_next = 1'b0;
        txdata_next     = ALIGN_DW;
        txdatak_next    = K0;
      end
      S_SEND_SYNC: begin
        txelecidle_next = 1'b0;
        txdata_next     = SYNC_DW;
        txdatak_next    = K0;
      end
      S_LINK_UP: begin
        txelecidle_next = 1'b0;
        link_up_next    = 1'b1;
        if (word_cnt_reg >= WORD_ALIGN) begin
          txdata_next  = ALIGN_DW;
          txdatak_next = K0;
        end else begin
          txdata_next      = txdata_ll;
          txdatak_next     = {3'b000, txdatak_ll};
          txdatak_pop_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/gtx_oob_dev.md
Name: gtx_oob_dev

Overview:
- Device-side SATA OOB and link-initialisation responder; the counterpart of the host-side OOB controller.
- Sits per lane between a GTX channel and a device-emulation link layer; used for device emulation and lane-to-lane loopback.
- Detects COMRESET, answers with COMINIT, exchanges COMWAKE, transmits ALIGN until host ALIGN lock, then sends SYNC and raises link_up.
- In link-up, passes link-layer dwords through and inserts an ALIGN pair every 256 dwords.

Parameters:
- C_COMWAKE_TIMEOUT, 75000: cycles to wait for host COMWAKE after COMINIT done before resending COMINIT.
- C_ALIGN_TIMEOUT, 66000: cycles (880 us at 75 MHz) to wait for host ALIGN before returning to IDLE.
- C_ALIGN_PERIOD, 256: dword period for ALIGN-pair insertion in link-up; must be >= 4.

Ports:
- sys_clk  in  1  GTX txusrclk2 domain clock.
- sys_rst  in  1  reset, asynchronous, active-high.
- rxstatus  in  3  GTX OOB status: 3'b011 COMRESET detected, 3'b010 COMWAKE detected, 3'b001 TX OOB burst done.
- rxelecidle  in  1  receiver electrical idle.
- rxbyteisaligned  in  1  comma alignment achieved.
- rxdata  in  32  received dword.
- rxdatak  in  4  received K flags.
- txdata_ll  in  32  link-layer transmit dword.
- txdatak_ll  in  1  link-layer K flag for byte 0.
- txcomstart  out  1  one-cycle OOB burst start.
- txcomtype  out  1  0 = COMINIT, 1 = COMWAKE.
- txelecidle  out  1  transmitter electrical idle.
- txdata  out  32  GTX transmit dword.
- txdatak  out  4  GTX transmit K flags.
- txdatak_pop  out  1  link-layer dword consumed this cycle.
- link_up  out  1  link established.
- oob_state  out  4  current state encoding, for debug.

Behaviour:
- Async reset (all outputs registered):
  - txcomstart = 0, txcomtype = 0, txelecidle = 1, txdata = 0, txdatak = 0, txdatak_pop = 0, link_up = 0.
  - State IDLE, counters cleared.
- Constants:
  - ALIGN = 32'h7B4A4ABC, K = 4'b0001.
  - SYNC = 32'hB5B5957C, K = 4'b0001.
- IDLE (0): txelecidle = 1. On rxstatus == 3'b011, go to SEND_COMINIT.
- SEND_COMINIT (1): txcomstart = 1 and txcomtype = 0 for exactly 1 cycle, then go to WAIT_COMINIT_DONE.
- WAIT_COMINIT_DONE (2): on rxstatus == 3'b001, go to WAIT_COMWAKE and clear the timer.
- WAIT_COMWAKE (3):
  - On rxstatus == 3'b010, go to SEND_COMWAKE.
  - When timer reaches C_COMWAKE_TIMEOUT-1, go to SEND_COMINIT (retry indefinitely).
- SEND_COMWAKE (4): txcomstart = 1 and txcomtype = 1 for 1 cycle, then go to WAIT_COMWAKE_DONE.
- WAIT_COMWAKE_DONE (5): on rxstatus == 3'b001, go to SEND_ALIGN and clear the timer.
- SEND_ALIGN (6):
  - txelecidle = 0; transmit ALIGN every cycle.
  - Exit condition: rxbyteisaligned = 1, rxelecidle = 0, rxdata == ALIGN and rxdatak == 4'b0001 in the same cycle. Then go to SEND_SYNC.
  - Timer reaching C_ALIGN_TIMEOUT-1 returns to IDLE with txelecidle = 1.
- SEND_SYNC (7):
  - Transmit SYNC; count consecutive received dwords with rxdatak[0] = 1 and rxdata != ALIGN.
  - Any ALIGN or non-K dword resets the count.
  - When the count reaches 3, go to LINK_UP and assert link_up on the same edge.
- LINK_UP (8):
  - Dword counter runs 0..C_ALIGN_PERIOD-1 and wraps.
  - At counts C_ALIGN_PERIOD-2 and C_ALIGN_PERIOD-1: transmit ALIGN, txdatak_pop = 0.
  - Otherwise: txdata = txdata_ll, txdatak = {3'b000, txdatak_ll}, txdatak_pop = 1.
  - Counter is cleared on LINK_UP entry, so the first ALIGN pair appears at dwords 254 and 255.
- Pipeline timing: txdata, txdatak and txdatak_pop are registered; txdatak_pop marks the cycle in which txdata_ll was sampled.
- COMRESET priority: rxstatus == 3'b011 in any state other than IDLE and SEND_COMINIT forces the next state to SEND_COMINIT. On that edge: link_up = 0, txelecidle = 1, txdatak_pop = 0, counters cleared.
- Simultaneous events: rxstatus == 3'b011 in the same cycle as a timeout takes the COMRESET path.
- rxstatus codes not listed for a state are ignored.
- Timers are 17 bits wide and saturate; they never wrap.

Test Plan:
- COMRESET → single-cycle txcomstart with txcomtype = 0. Then:
  1. Drive rxstatus = 3'b001 → WAIT_COMWAKE.
  2. Drive 3'b010 → single-cycle txcomstart with txcomtype = 1.
  3. Drive 3'b001 → txdata = 32'h7B4A4ABC, txdatak = 4'b0001, txelecidle = 0.
- Full bring-up:
  1. Feed host ALIGN with rxbyteisaligned = 1 → txdata = 32'hB5B5957C.
  2. Feed 3 SYNC dwords → link_up = 1 on the 3rd-dword edge.
  3. 2 SYNC followed by 1 ALIGN does not raise link_up.
- Link-up streaming: incrementing txdata_ll from 0 →
  - dwords 0..253 pass through with txdatak_pop = 1;
  - dwords 254-255 are ALIGN with txdatak_pop = 0;
  - txdata_ll value 254 is transmitted at dword 256;
  - pattern repeats every 256.
- Timeouts, C_COMWAKE_TIMEOUT = 100:
  - no COMWAKE → second COMINIT txcomstart exactly 100 cycles after WAIT_COMWAKE entry;
  - C_ALIGN_TIMEOUT = 200 with no host ALIGN → IDLE with txelecidle = 1 after 200 cycles.
- COMRESET while link_up = 1 → next edge link_up = 0, txelecidle = 1, txdatak_pop = 0, then COMINIT txcomstart; also applied coincident with an ALIGN timeout → COMINIT path wins.
- Assert sys_rst asynchronously mid-SEND_ALIGN → outputs go to reset values immediately, without waiting for a clock edge; oob_state = 0.
